// File: rtl/uart_tx_feeder.sv
// ----------------------------------------------------------------------------
// uart_tx_feeder
//   Byte buffer and sequencer that sits directly in front of the UART
//   transmitter. Bytes from the sort FSM are queued in a DEPTH-entry FIFO.
//   They are handed to the transmitter one at a time through its DV/Byte/Done
//   handshake. Each byte is held until the transmitter reports completion.
//
// Optional feature macro: UART_TX_FEED_GAP_EN
//   When defined, GAP_CLKS idle clocks are inserted after every i_Tx_Done
//   before the next launch. When undefined, the gap state and its counter
//   are not built.
//
// Ports
//   i_Clock      system clock, rising edge
//   i_Reset      synchronous active-high reset
//   i_Wr_DV      write strobe, one byte per cycle while high
//   i_Wr_Byte    byte to enqueue
//   o_Full       FIFO holds DEPTH bytes
//   o_Empty      FIFO holds 0 bytes
//   o_Count      bytes currently stored (0..DEPTH)
//   o_Overflow   sticky flag: a write was dropped while full
//   o_Tx_DV      one-cycle launch pulse to the transmitter
//   o_Tx_Byte    byte being sent, stable from launch until done
//   i_Tx_Active  transmitter busy
//   i_Tx_Done    transmitter one-cycle completion pulse
// ----------------------------------------------------------------------------
module uart_tx_feeder #(
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 3,
    parameter int GAP_CLKS = 16
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Wr_DV,
    input  logic [7:0]        i_Wr_Byte,
    output logic              o_Full,
    output logic              o_Empty,
    output logic [ADDR_W:0]   o_Count,
    output logic              o_Overflow,
    output logic              o_Tx_DV,
    output logic [7:0]        o_Tx_Byte,
    input  logic              i_Tx_Active,
    input  logic              i_Tx_Done
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_DONE = 2'd1
`ifdef UART_TX_FEED_GAP_EN
        ,S_GAP      = 2'd2
`endif
    } state_t;

    // Pointers wrap naturally, so the configuration must be a power of two.
    if (DEPTH < 2 || DEPTH != (1 << ADDR_W) || GAP_CLKS < 1) begin : g_paramCheck
        $error("uart_tx_feeder: DEPTH must equal 2**ADDR_W and be >= 2; GAP_CLKS must be >= 1");
    end

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wrPtr_q;
    logic [ADDR_W-1:0] rdPtr_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_d;
    logic              full_q;
    logic              empty_q;
    logic              overflow_q;
    logic              txDv_q;
    logic [7:0]        txByte_q;
    state_t            state_q;
    logic              wrAccept;
    logic              pop;

`ifdef UART_TX_FEED_GAP_EN
    localparam int GAP_W = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
    logic [GAP_W-1:0]  gapCnt_q;
`endif

    // Full is judged on the registered (pre-edge) count, so a pop in the
    // same cycle never rescues a write made while full.
    always_comb begin
        wrAccept = i_Wr_DV && !full_q;
        pop      = (state_q == S_IDLE) && !empty_q && !i_Tx_Active;
        count_d  = count_q;
        if (wrAccept && !pop) begin
            count_d = count_q + (ADDR_W+1)'(1);
        end else if (!wrAccept && pop) begin
            count_d = count_q - (ADDR_W+1)'(1);
        end
    end

    // Storage array kept free of reset so it maps onto plain memory.
    always_ff @(posedge i_Clock) begin
        if (wrAccept) begin
            mem_q[wrPtr_q] <= i_Wr_Byte;
        end
    end

    // FIFO bookkeeping; flags are registered from the next-state count.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (wrAccept) begin
                wrPtr_q <= wrPtr_q + ADDR_W'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + ADDR_W'(1);
            end
            if (i_Wr_DV && full_q) begin
                overflow_q <= 1'b1;
            end
            count_q <= count_d;
            full_q  <= (count_d == (ADDR_W+1)'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    // Launch sequencer. The head byte is latched into the output register
    // at pop time so it stays stable for the whole transmission.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q  <= S_IDLE;
            txDv_q   <= 1'b0;
            txByte_q <= 8'h00;
`ifdef UART_TX_FEED_GAP_EN
            gapCnt_q <= '0;
`endif
        end else begin
            txDv_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        txByte_q <= mem_q[rdPtr_q];
                        txDv_q   <= 1'b1;
                        state_q  <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (i_Tx_Done) begin
`ifdef UART_TX_FEED_GAP_EN
                        state_q  <= S_GAP;
                        gapCnt_q <= '0;
`else
                        state_q  <= S_IDLE;
`endif
                    end
                end
`ifdef UART_TX_FEED_GAP_EN
                S_GAP: begin
                    if (gapCnt_q == GAP_W'(GAP_CLKS - 1)) begin
                        state_q <= S_IDLE;
                    end else begin
                        gapCnt_q <= gapCnt_q + GAP_W'(1);
                    end
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_Full     = full_q;
    assign o_Empty    = empty_q;
    assign o_Count    = count_q;
    assign o_Overflow = overflow_q;
    assign o_Tx_DV    = txDv_q;
    assign o_Tx_Byte  = txByte_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_feeder
//   Self-checking bench for uart_tx_feeder. A scoreboard queue holds the
//   bytes expected to be launched; a small transmitter model answers each
//   launch with a Done pulse; a table of vectors exercises fill/overflow.
// ----------------------------------------------------------------------------
module tb_uart_tx_feeder;

    localparam int DEPTH    = 8;
    localparam int ADDR_W   = 3;
    localparam int GAP_CLKS = 16;
`ifdef UART_TX_FEED_GAP_EN
    localparam int EXP_DONE_TO_DV = GAP_CLKS + 2;
`else
    localparam int EXP_DONE_TO_DV = 2;
`endif
    localparam int SETTLE = EXP_DONE_TO_DV + 2;

    logic              i_Clock;
    logic              i_Reset;
    logic              i_Wr_DV;
    logic [7:0]        i_Wr_Byte;
    logic              o_Full;
    logic              o_Empty;
    logic [ADDR_W:0]   o_Count;
    logic              o_Overflow;
    logic              o_Tx_DV;
    logic [7:0]        o_Tx_Byte;
    logic              i_Tx_Active;
    logic              i_Tx_Done;

    typedef struct {
        logic            wrDv;
        logic [7:0]      wrByte;
        logic            accept;
        logic [ADDR_W:0] expCount;
        logic            expFull;
        logic            expEmpty;
        logic            expOvf;
    } vec_t;

    vec_t        vecs [10];
    logic [7:0]  expQ [$];
    int          testsRun    = 0;
    int          testsFailed = 0;
    int          cyc         = 0;
    int          dvCount     = 0;
    int          dvBase      = 0;
    int          fullRun     = 0;
    int          fullRunMax  = 0;
    int          doneCnt     = 0;
    int          doneDelay   = 10;
    int          lastDoneCyc = 0;
    bit          autoDone    = 1'b1;
    bit          manualDone  = 1'b0;
    bit          xmitBusy    = 1'b0;
    bit          haveDone    = 1'b0;
    bit          measureGap  = 1'b0;
    bit          prevDv      = 1'b0;

    uart_tx_feeder #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .GAP_CLKS (GAP_CLKS)
    ) dut (
        .i_Clock     (i_Clock),
        .i_Reset     (i_Reset),
        .i_Wr_DV     (i_Wr_DV),
        .i_Wr_Byte   (i_Wr_Byte),
        .o_Full      (o_Full),
        .o_Empty     (o_Empty),
        .o_Count     (o_Count),
        .o_Overflow  (o_Overflow),
        .o_Tx_DV     (o_Tx_DV),
        .o_Tx_Byte   (o_Tx_Byte),
        .i_Tx_Active (i_Tx_Active),
        .i_Tx_Done   (i_Tx_Done)
    );

    // Free-running clock and a cycle stamp used for timing checks.
    initial begin
        i_Clock = 1'b0;
        forever #5 i_Clock = ~i_Clock;
    end

    always @(posedge i_Clock) begin
        cyc = cyc + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one cycle of write inputs; accepted bytes go on the scoreboard.
    task automatic applyStimulus(input logic wrDv, input logic [7:0] b, input bit accept);
        @(negedge i_Clock);
        i_Wr_DV   = wrDv;
        i_Wr_Byte = b;
        if (wrDv && accept) begin
            expQ.push_back(b);
        end
    endtask

    task automatic waitIdle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge i_Clock);
            if (expQ.size() == 0 && !xmitBusy && !o_Tx_DV) begin
                break;
            end
        end
        checkOutput("drainComplete", expQ.size(), 0);
        repeat (SETTLE) @(negedge i_Clock);
    endtask

    // Transmitter model: Done arrives doneDelay clocks after each launch.
    always @(negedge i_Clock) begin
        i_Tx_Done = 1'b0;
        if (manualDone) begin
            i_Tx_Done  = 1'b1;
            manualDone = 1'b0;
        end else if (xmitBusy) begin
            if (doneCnt <= 1) begin
                i_Tx_Done   = 1'b1;
                xmitBusy    = 1'b0;
                lastDoneCyc = cyc;
                haveDone    = 1'b1;
            end else begin
                doneCnt--;
            end
        end else if (autoDone && o_Tx_DV && !i_Reset) begin
            xmitBusy = 1'b1;
            doneCnt  = doneDelay;
        end
    end

    // Launch monitor: pops the scoreboard on every DV pulse.
    always @(negedge i_Clock) begin
        if (!i_Reset) begin
            if (o_Full) fullRun++;
            else        fullRun = 0;
            if (fullRun > fullRunMax) fullRunMax = fullRun;
            if (o_Tx_DV) begin
                dvCount++;
                checkOutput("dvPulseWidth", prevDv, 0);
                checkOutput("launchQueued", (expQ.size() > 0), 1);
                if (expQ.size() > 0) begin
                    checkOutput("launchByte", o_Tx_Byte, expQ.pop_front());
                end
                if (measureGap && haveDone) begin
                    checkOutput("doneToDv", cyc - lastDoneCyc, EXP_DONE_TO_DV);
                end
            end
            prevDv = o_Tx_DV;
        end else begin
            prevDv = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Fill/overflow vectors, applied with the transmitter held busy.
        vecs[0] = '{1'b1, 8'h10, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'h11, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 8'h12, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 8'h13, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 8'h14, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 8'h15, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 8'h16, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 8'h17, 1'b1, 4'd8, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 8'hFF, 1'b0, 4'd8, 1'b1, 1'b0, 1'b1};
        vecs[9] = '{1'b0, 8'h00, 1'b0, 4'd8, 1'b1, 1'b0, 1'b1};

        i_Reset     = 1'b1;
        i_Wr_DV     = 1'b0;
        i_Wr_Byte   = 8'h00;
        i_Tx_Active = 1'b0;
        repeat (3) @(posedge i_Clock);
        @(negedge i_Clock);
        i_Reset = 1'b0;

        // Reset state
        checkOutput("rstEmpty", o_Empty, 1);
        checkOutput("rstFull", o_Full, 0);
        checkOutput("rstOverflow", o_Overflow, 0);
        checkOutput("rstTxDv", o_Tx_DV, 0);
        checkOutput("rstTxByte", o_Tx_Byte, 8'h00);
        checkOutput("rstCount", o_Count, 0);

        // Single byte: launch in the cycle after the second edge
        applyStimulus(1'b1, 8'hA5, 1'b1);
        @(posedge i_Clock); #1;
        checkOutput("t1Count", o_Count, 1);
        checkOutput("t1NotEmpty", o_Empty, 0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        @(posedge i_Clock); #1;
        checkOutput("t1TxDv", o_Tx_DV, 1);
        checkOutput("t1TxByte", o_Tx_Byte, 8'hA5);
        checkOutput("t1EmptyAfterPop", o_Empty, 1);
        waitIdle(300);

        // Eight back-to-back writes, done 10 clocks after each launch
        dvBase     = dvCount;
        haveDone   = 1'b0;
        fullRun    = 0;
        fullRunMax = 0;
        measureGap = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b1);
        end
        applyStimulus(1'b0, 8'h00, 1'b0);
        waitIdle(800);
        measureGap = 1'b0;
        checkOutput("t2DvPulses", dvCount - dvBase, 8);
        checkOutput("t2FullRunOver1", (fullRunMax > 1), 0);

        // Fill and overflow with the transmitter reporting busy
        @(negedge i_Clock);
        i_Tx_Active = 1'b1;
        dvBase = dvCount;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].wrDv, vecs[i].wrByte, vecs[i].accept);
            @(posedge i_Clock); #1;
            checkOutput($sformatf("vec%0d.count", i), o_Count, vecs[i].expCount);
            checkOutput($sformatf("vec%0d.full", i), o_Full, vecs[i].expFull);
            checkOutput($sformatf("vec%0d.empty", i), o_Empty, vecs[i].expEmpty);
            checkOutput($sformatf("vec%0d.overflow", i), o_Overflow, vecs[i].expOvf);
        end
        checkOutput("t5NoDvWhileActive", dvCount - dvBase, 0);

        // Launch on the cycle after Active drops
        @(negedge i_Clock);
        i_Tx_Active = 1'b0;
        @(posedge i_Clock); #1;
        checkOutput("t5TxDv", o_Tx_DV, 1);
        checkOutput("t5TxByte", o_Tx_Byte, 8'h10);
        checkOutput("t5Count", o_Count, 7);
        waitIdle(800);
        checkOutput("t3Launches", dvCount - dvBase, 8);
        checkOutput("t3OverflowSticky", o_Overflow, 1);

        // Twenty bytes in bursts of five across pointer wrap
        dvBase = dvCount;
        for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < 5; j++) begin
                applyStimulus(1'b1, 8'(8'h40 + b * 5 + j), 1'b1);
            end
            applyStimulus(1'b0, 8'h00, 1'b0);
            waitIdle(600);
        end
        checkOutput("t4Launches", dvCount - dvBase, 20);

        // Reset while waiting for Done with three bytes queued
        autoDone = 1'b0;
        for (int j = 0; j < 4; j++) begin
            applyStimulus(1'b1, 8'(8'hC0 + j), 1'b1);
        end
        applyStimulus(1'b0, 8'h00, 1'b0);
        repeat (2) @(negedge i_Clock);
        checkOutput("t6CountBefore", o_Count, 3);
        i_Reset = 1'b1;
        @(posedge i_Clock); #1;
        expQ.delete();
        checkOutput("t6Count", o_Count, 0);
        checkOutput("t6TxDv", o_Tx_DV, 0);
        checkOutput("t6Empty", o_Empty, 1);
        checkOutput("t6Overflow", o_Overflow, 0);
        checkOutput("t6TxByte", o_Tx_Byte, 8'h00);
        @(negedge i_Clock);
        i_Reset    = 1'b0;
        manualDone = 1'b1;
        dvBase     = dvCount;
        repeat (5) @(negedge i_Clock);
        checkOutput("t6NoLaunchAfterLateDone", dvCount - dvBase, 0);
        autoDone = 1'b1;
        applyStimulus(1'b1, 8'h5A, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        @(posedge i_Clock); #1;
        checkOutput("t6IdleLaunch", o_Tx_DV, 1);
        checkOutput("t6IdleByte", o_Tx_Byte, 8'h5A);
        waitIdle(300);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
